config_loader: RTL

- Bitstream sequencer for the fabric configuration chain (connector boxes, switch boxes, LUTs daisy-chained via config_in/config_out).
- Accepts packed configuration words over a valid/ready stream and serialises them onto the chain.
- Generates config_clk and config_en, replacing the bench-side bit-banging task with synthesizable RTL.
- Sits between the bitstream source (ROM/UART/host FIFO) and the head of the chain.

---
 rtl/config_loader.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/config_loader.sv
// ----------------------------------------------------------------------------
// config_loader
//
// Bitstream sequencer for the fabric configuration chain. Packed configuration
// words arrive over a valid/ready stream and are serialised LSB-first onto the
// daisy-chained configuration shift register, with a generated shift clock
// (config_clk) and shift enable (config_en).
//
// Global chain bit k comes from word k/WORD_WIDTH, bit k%WORD_WIDTH. Bit 0 is
// shifted first and therefore ends up deepest in the chain. When CHAIN_LEN is
// not a multiple of WORD_WIDTH the unused upper bits of the last word are
// dropped and no extra word is fetched.
//
// Parameters:
//   CHAIN_LEN   total configuration bits in the chain
//   WORD_WIDTH  width of incoming bitstream words
//   CLK_DIV     clk cycles per config_clk half-period (>= 1)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       single-cycle pulse, begins a load when idle
//   abort       terminates the current load (highest priority when busy)
//   in_data     bitstream word, LSB shifted first
//   in_valid    in_data valid
//   in_ready    word accepted when in_valid && in_ready
//   config_in   serial data to the chain head
//   config_clk  generated chain shift clock (registered, glitch-free)
//   config_en   chain shift enable
//   busy        high whenever a load is in progress (any state but idle)
//   done        one-cycle pulse on successful completion
//   aborted     one-cycle pulse when a load is aborted
//
// Optional feature (macro CONFIG_LOADER_CRC_EN):
//   crc         CRC-8 (poly 0x07, init 0x00) over every bit shifted
//   crc_valid   pulses together with done
// ----------------------------------------------------------------------------
module config_loader #(
    parameter int unsigned CHAIN_LEN  = 72,
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  config_in,
    output logic                  config_clk,
    output logic                  config_en,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
`ifdef CONFIG_LOADER_CRC_EN
    ,
    output logic [7:0]            crc,
    output logic                  crc_valid
`endif
);

    // Counter widths; a width of at least 1 keeps degenerate sizes legal.
    localparam int unsigned BIT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_DONE
    } state_t;

    state_t                state;
    logic [BIT_W-1:0]      bit_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DIV_W-1:0]      div_cnt;
    logic [WORD_WIDTH-1:0] word_sr;

    logic [BIT_W-1:0]      bit_cnt_nxt;
    logic                  div_tc;
    logic                  last_bit;
    logic                  word_end;

    // The current bit always sits in word_sr[0]; the output is therefore
    // taken straight from a flop and cannot glitch.
    assign config_in   = word_sr[0];

    assign bit_cnt_nxt = bit_cnt + 1'b1;
    assign div_tc      = (div_cnt == DIV_LAST);
    assign last_bit    = (bit_cnt_nxt == BIT_LAST);
    assign word_end    = (bit_idx == IDX_LAST);

`ifdef CONFIG_LOADER_CRC_EN
    logic [7:0] crc_nxt;
    logic       crc_fb;

    // Serial CRC-8, x^8 + x^2 + x + 1, MSB-first shift of the bit stream.
    always_comb begin
        crc_fb  = crc[7] ^ config_in;
        crc_nxt = {crc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            div_cnt    <= '0;
            word_sr    <= '0;
            in_ready   <= 1'b0;
            config_clk <= 1'b0;
            config_en  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
            crc        <= '0;
            crc_valid  <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
            crc_valid <= 1'b0;
`endif
            if (state != S_IDLE && abort) begin
                // Abort cuts any config_clk high phase short; no further
                // chain edges are issued.
                state      <= S_IDLE;
                div_cnt    <= '0;
                word_sr    <= '0;
                in_ready   <= 1'b0;
                config_clk <= 1'b0;
                config_en  <= 1'b0;
                busy       <= 1'b0;
                aborted    <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state     <= S_FETCH;
                            bit_cnt   <= '0;
                            bit_idx   <= '0;
                            div_cnt   <= '0;
                            in_ready  <= 1'b1;
                            config_en <= 1'b1;
                            busy      <= 1'b1;
`ifdef CONFIG_LOADER_CRC_EN
                            crc       <= '0;
`endif
                        end
                    end

                    S_FETCH: begin
                        // Without a word the chain simply waits here with
                        // config_clk low and config_en high.
                        if (in_valid) begin
                            state    <= S_SHIFT_LO;
                            word_sr  <= in_data;
                            bit_idx  <= '0;
                            div_cnt  <= '0;
                            in_ready <= 1'b0;
                        end
                    end

                    S_SHIFT_LO: begin
                        if (div_tc) begin
                            state      <= S_SHIFT_HI;
                            div_cnt    <= '0;
                            config_clk <= 1'b1;
`ifdef CONFIG_LOADER_CRC_EN
                            crc        <= crc_nxt;
`endif
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end

                    S_SHIFT_HI: begin
                        if (div_tc) begin
                            div_cnt    <= '0;
                            config_clk <= 1'b0;
                            bit_cnt    <= bit_cnt_nxt;
                            // Chain-full is tested before word-exhausted so a
                            // partial last word never triggers another fetch.
                            if (last_bit) begin
                                state     <= S_DONE;
                                word_sr   <= '0;
                                config_en <= 1'b0;
                                done      <= 1'b1;
`ifdef CONFIG_LOADER_CRC_EN
                                crc_valid <= 1'b1;
`endif
                            end else if (word_end) begin
                                state    <= S_FETCH;
                                in_ready <= 1'b1;
                            end else begin
                                state   <= S_SHIFT_LO;
                                bit_idx <= bit_idx + 1'b1;
                                word_sr <= word_sr >> 1;
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end

                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end

                    default: begin
                        state      <= S_IDLE;
                        in_ready   <= 1'b0;
                        config_clk <= 1'b0;
                        config_en  <= 1'b0;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
